// File: rtl/uart_tx_frame_sched.sv
// Serialises one captured X/Y/Z sample as an ASCII hex text frame, one byte per uart_tx job.
// Optional checksum ('*' + two hex digits of the sample-byte XOR) enabled by UART_SCHED_CKSUM_EN.
module uart_tx_frame_sched #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned EOL_CR = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_smp_valid,
  input  logic [DATA_W-1:0] i_smp_x,
  input  logic [DATA_W-1:0] i_smp_y,
  input  logic [DATA_W-1:0] i_smp_z,
  output logic              o_smp_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_enb,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_drop,
  output logic [7:0]        o_drop_cnt
);

  localparam int unsigned NDig = DATA_W / 4;
`ifdef UART_SCHED_CKSUM_EN
  localparam int unsigned CkLen = 3;
`else
  localparam int unsigned CkLen = 0;
`endif
  localparam int unsigned FrameLen = 3 * NDig + 2 + CkLen + ((EOL_CR != 0) ? 2 : 1);
  localparam int unsigned IdxW = $clog2(FrameLen);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_enb_q, tx_enb_d;
  logic              drop_q, drop_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [7:0]        byte_sel;
  logic              last_byte;
  int unsigned       pos;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Digit d counts from the most significant nibble.
  function automatic logic [3:0] nib(input logic [DATA_W-1:0] v, input int unsigned d);
    return 4'(v >> (4 * (NDig - 1 - d)));
  endfunction

`ifdef UART_SCHED_CKSUM_EN
  localparam int unsigned NByte = (DATA_W + 7) / 8;
  logic [NByte*8-1:0] xe, ye, ze;
  logic [7:0]         cksum;

  always_comb begin
    xe = '0;
    ye = '0;
    ze = '0;
    xe[DATA_W-1:0] = x_q;
    ye[DATA_W-1:0] = y_q;
    ze[DATA_W-1:0] = z_q;
    cksum = 8'h00;
    for (int b = 0; b < int'(NByte); b++) begin
      cksum = cksum ^ xe[b*8 +: 8] ^ ye[b*8 +: 8] ^ ze[b*8 +: 8];
    end
  end
`endif

  always_comb begin
    pos      = 32'(idx_q);
    byte_sel = 8'h0A;
    if (pos < NDig)                  byte_sel = hex_char(nib(x_q, pos));
    else if (pos == NDig)            byte_sel = 8'h20;
    else if (pos < 2 * NDig + 1)     byte_sel = hex_char(nib(y_q, pos - NDig - 1));
    else if (pos == 2 * NDig + 1)    byte_sel = 8'h20;
    else if (pos < 3 * NDig + 2)     byte_sel = hex_char(nib(z_q, pos - 2 * NDig - 2));
`ifdef UART_SCHED_CKSUM_EN
    else if (pos == 3 * NDig + 2)    byte_sel = 8'h2A;
    else if (pos == 3 * NDig + 3)    byte_sel = hex_char(cksum[7:4]);
    else if (pos == 3 * NDig + 4)    byte_sel = hex_char(cksum[3:0]);
`endif
    else if ((EOL_CR != 0) && (pos == FrameLen - 2)) byte_sel = 8'h0D;
  end

  assign last_byte = (idx_q == IdxW'(FrameLen - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (i_smp_valid) begin
          x_d     = i_smp_x;
          y_d     = i_smp_y;
          z_d     = i_smp_z;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:      if (i_tx_ready) state_d = S_REQ;
      S_REQ:       state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (!i_tx_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_tx_ready) begin
          if (last_byte) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = S_LOAD;
          end
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Data only moves while in S_LOAD, so it is stable through the request/ack handshake.
  always_comb begin
    tx_data_d  = (state_q == S_LOAD) ? byte_sel : tx_data_q;
    tx_enb_d   = (state_d == S_REQ);
    drop_d     = i_smp_valid && (state_q != S_IDLE);
    drop_cnt_d = (drop_d && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      tx_data_q  <= 8'h00;
      tx_enb_q   <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      tx_data_q  <= tx_data_d;
      tx_enb_q   <= tx_enb_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_smp_ready = (state_q == S_IDLE);
  assign o_busy      = ~o_smp_ready;
  assign o_tx_data   = tx_data_q;
  assign o_tx_enb    = tx_enb_q;
  assign o_drop      = drop_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// Directed/randomised bench: uart_tx busy model feeds i_tx_ready, sent bytes are compared with
// a text-frame reference built from the sample values.
module tb_uart_tx_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_valid = 1'b0;
  logic [15:0] sx = '0, sy = '0, sz = '0;
  logic        smp_ready, busy, drop, tx_enb, tx_ready;
  logic [7:0]  tx_data, drop_cnt;

  logic        valid2 = 1'b0;
  logic [15:0] s2 = 16'hFFFF;
  logic        smp_ready2, busy2, drop2, tx_enb2, tx_ready2;
  logic [7:0]  tx_data2, drop_cnt2;

  int          total = 0;
  int          bad = 0;
  int          busy_n = 0;
  int          busy_n2 = 0;
  bit          hold = 1'b0;
  int          proto_err = 0;
  int          enb_seen;
  logic [7:0]  got[$];
  logic [7:0]  got2[$];
  logic [7:0]  exp_q[$];
  logic [15:0] ax, ay, az;

  always #5 clk = ~clk;

  uart_tx_frame_sched u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_smp_valid (smp_valid),
    .i_smp_x     (sx),
    .i_smp_y     (sy),
    .i_smp_z     (sz),
    .o_smp_ready (smp_ready),
    .o_tx_data   (tx_data),
    .o_tx_enb    (tx_enb),
    .i_tx_ready  (tx_ready),
    .o_busy      (busy),
    .o_drop      (drop),
    .o_drop_cnt  (drop_cnt)
  );

  uart_tx_frame_sched #(.DATA_W(16), .EOL_CR(0)) u_dut_lf (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_smp_valid (valid2),
    .i_smp_x     (s2),
    .i_smp_y     (s2),
    .i_smp_z     (s2),
    .o_smp_ready (smp_ready2),
    .o_tx_data   (tx_data2),
    .o_tx_enb    (tx_enb2),
    .i_tx_ready  (tx_ready2),
    .o_busy      (busy2),
    .o_drop      (drop2),
    .o_drop_cnt  (drop_cnt2)
  );

  // uart_tx stand-in: busy for a random number of cycles after each enable.
  assign tx_ready  = (busy_n == 0) && !hold;
  assign tx_ready2 = (busy_n2 == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_n <= 0;
    end else if (tx_enb) begin
      got.push_back(tx_data);
      if (busy_n != 0 || hold) proto_err++;
      busy_n <= 2 + int'($urandom_range(0, 6));
    end else if (busy_n != 0) begin
      busy_n <= busy_n - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_n2 <= 0;
    end else if (tx_enb2) begin
      got2.push_back(tx_data2);
      if (busy_n2 != 0) proto_err++;
      busy_n2 <= 2 + int'($urandom_range(0, 6));
    end else if (busy_n2 != 0) begin
      busy_n2 <= busy_n2 - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic make_exp(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input bit cr);
    logic [15:0] v[3];
    string       h;
`ifdef UART_SCHED_CKSUM_EN
    logic [7:0]  ck;
    ck = 8'h00;
`endif
    h = "0123456789ABCDEF";
    v[0] = x;
    v[1] = y;
    v[2] = z;
    exp_q.delete();
    for (int a = 0; a < 3; a++) begin
      for (int d = 3; d >= 0; d--) exp_q.push_back(h[v[a][d*4 +: 4]]);
      if (a < 2) exp_q.push_back(8'h20);
`ifdef UART_SCHED_CKSUM_EN
      ck = ck ^ v[a][15:8] ^ v[a][7:0];
`endif
    end
`ifdef UART_SCHED_CKSUM_EN
    exp_q.push_back(8'h2A);
    exp_q.push_back(h[ck[7:4]]);
    exp_q.push_back(h[ck[3:0]]);
`endif
    if (cr) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_valid(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sx = x;
    sy = y;
    sz = z;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int t;
    t = 0;
    while (!(got.size() >= exp_q.size() && smp_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " done_in_time"}, 32'(t < 5000), 32'd1);
    chk({tag, " byte_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst tx_data", 32'(tx_data), 32'h00);
    chk("rst tx_enb", 32'(tx_enb), 32'd0);
    chk("rst smp_ready", 32'(smp_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst drop", 32'(drop), 32'd0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Latency and the reference frame.
    got.delete();
    make_exp(16'h1234, 16'hABCD, 16'h00F0, 1'b1);
    pulse_valid(16'h1234, 16'hABCD, 16'h00F0);
    chk("lat k+1 enb", 32'(tx_enb), 32'd0);
    chk("lat k+1 busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat k+2 enb", 32'(tx_enb), 32'd1);
    chk("lat k+2 data", 32'(tx_data), 32'h31);
    @(negedge clk);
    chk("lat k+3 enb", 32'(tx_enb), 32'd0);
    check_frame("ref");

    // Random samples.
    for (int n = 0; n < 3; n++) begin
      ax = 16'($urandom);
      ay = 16'($urandom);
      az = 16'($urandom);
      got.delete();
      make_exp(ax, ay, az, 1'b1);
      pulse_valid(ax, ay, az);
      check_frame($sformatf("rand%0d", n));
    end

    // Samples during a frame are dropped and counted.
    ax = 16'($urandom);
    ay = 16'($urandom);
    az = 16'($urandom);
    got.delete();
    make_exp(ax, ay, az, 1'b1);
    pulse_valid(ax, ay, az);
    while (got.size() < 2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      pulse_valid(~ax, ~ay, ~az);
      chk($sformatf("drop%0d pulse", d), 32'(drop), 32'd1);
      chk($sformatf("drop%0d cnt", d), 32'(drop_cnt), 32'(d + 1));
      @(negedge clk);
      chk($sformatf("drop%0d pulse_end", d), 32'(drop), 32'd0);
    end
    check_frame("drop frame");
    chk("drop final cnt", 32'(drop_cnt), 32'd3);

    // uart_tx held busy: no enable, long drop burst saturates the counter.
    hold = 1'b1;
    ax = 16'($urandom);
    ay = 16'($urandom);
    az = 16'($urandom);
    got.delete();
    make_exp(ax, ay, az, 1'b1);
    pulse_valid(ax, ay, az);
    enb_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_enb) enb_seen++;
    end
    chk("hold enb", 32'(enb_seen), 32'd0);
    chk("hold busy", 32'(busy), 32'd1);
    smp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sx = 16'(i);
      @(negedge clk);
      if (tx_enb) enb_seen++;
    end
    smp_valid = 1'b0;
    @(negedge clk);
    chk("sat cnt", 32'(drop_cnt), 32'hFF);
    chk("sat hold enb", 32'(enb_seen), 32'd0);
    hold = 1'b0;
    check_frame("hold frame");

    // Reset partway through a frame.
    ax = 16'($urandom);
    ay = 16'($urandom);
    az = 16'($urandom);
    got.delete();
    pulse_valid(ax, ay, az);
    enb_seen = 0;
    while (got.size() < 7 && enb_seen < 5000) begin
      @(negedge clk);
      enb_seen++;
    end
    chk("midrst reached byte7", 32'(got.size()), 32'd7);
    rst = 1'b1;
    #1;
    chk("midrst tx_data", 32'(tx_data), 32'h00);
    chk("midrst tx_enb", 32'(tx_enb), 32'd0);
    chk("midrst smp_ready", 32'(smp_ready), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst drop", 32'(drop), 32'd0);
    chk("midrst drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got.delete();
    ax = 16'($urandom);
    ay = 16'($urandom);
    az = 16'($urandom);
    make_exp(ax, ay, az, 1'b1);
    pulse_valid(ax, ay, az);
    check_frame("after rst");

    // LF-only instance.
    got2.delete();
    make_exp(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    enb_seen = 0;
    while (!(got2.size() >= exp_q.size() && smp_ready2) && enb_seen < 5000) begin
      @(negedge clk);
      enb_seen++;
    end
    chk("lf byte_count", 32'(got2.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got2.size(); i++)
      chk($sformatf("lf byte%0d", i), 32'(got2[i]), 32'(exp_q[i]));

    chk("enb protocol errors", 32'(proto_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
